// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between the icache miss path and the dcache miss/writeback path.
// One line transaction at a time, round-robin tie-break, sticky watchdog on a hung memory.
//
// state      | meaning
// IDLE       | no transaction in flight; arbitrate between i and d requests
// GRANT_I    | icache read owns pmem; wait for pmem_resp
// GRANT_D    | dcache read or writeback owns pmem; wait for pmem_resp
module pmem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              pmem_timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_d;
  logic                r_pmem_read;
  logic                r_pmem_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic [15:0]         r_wdog;
  logic                r_timeout;

  logic                w_req_i;
  logic                w_req_d;
  logic                w_grant_i;
  logic                w_grant_d;
  logic                w_done;
  logic [15:0]         w_wdog_inc;

  assign w_req_i    = i_read;
  assign w_req_d    = d_read | d_write;
  assign w_wdog_inc = r_wdog + 16'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_done      = 1'b0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    case (r_state)
      IDLE: begin
        // on a tie, the requester that did not win last time goes first
        w_grant_d = w_req_d && (!w_req_i || !r_last_d);
        w_grant_i = w_req_i && (!w_req_d ||  r_last_d);
        if (w_grant_d)      w_state_nxt = GRANT_D;
        else if (w_grant_i) w_state_nxt = GRANT_I;
      end
      GRANT_I: begin
        w_done = pmem_resp;
        i_resp = pmem_resp;
        if (pmem_resp) w_state_nxt = IDLE;
      end
      GRANT_D: begin
        w_done = pmem_resp;
        d_resp = pmem_resp;
        if (pmem_resp) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_d     <= 1'b0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wdog       <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_d) begin
        r_addr       <= d_address;
        r_wdata      <= d_wdata;
        r_pmem_write <= d_write;
        r_pmem_read  <= ~d_write;
        r_last_d     <= 1'b1;
        r_wdog       <= '0;
      end else if (w_grant_i) begin
        r_addr       <= i_address;
        r_pmem_read  <= 1'b1;
        r_pmem_write <= 1'b0;
        r_last_d     <= 1'b0;
        r_wdog       <= '0;
      end else if (w_done) begin
        r_pmem_read  <= 1'b0;
        r_pmem_write <= 1'b0;
      end else if (r_state != IDLE && r_wdog != TO_CNT) begin
        r_wdog <= w_wdog_inc;
        if (w_wdog_inc == TO_CNT) r_timeout <= 1'b1;
      end
    end
  end

  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign pmem_timeout = r_timeout;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios plus randomized traffic, all checked cycle by cycle
// against a transaction-level model of who owns the memory port.
module tb_pmem_arbiter;

  localparam int ADDR_W  = 16;
  localparam int LINE_W  = 128;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_address = '0;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_address = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata = '0;
  logic              pmem_resp = 1'b0;
  logic              pmem_timeout;

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .pmem_timeout(pmem_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model: owner 0 = nobody, 1 = icache, 2 = dcache
  int                m_owner;
  bit                m_last_d;
  bit                m_is_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  int                m_wait;
  bit                m_to;
  bit                m_i_done;
  bit                m_d_done;
  int                grant_log[$];

  task automatic check_val(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = 0;
    m_last_d = 1'b0;
    m_is_wr  = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_wait   = 0;
    m_to     = 1'b0;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // one clock cycle: drive inputs, check outputs against the model, then advance the model
  task automatic step(input logic ir, input logic [ADDR_W-1:0] ia,
                      input logic dr, input logic dw, input logic [ADDR_W-1:0] da,
                      input logic [LINE_W-1:0] dwd, input logic pr, input logic [LINE_W-1:0] prd);
    int pick;
    @(negedge clk);
    i_read = ir; i_address = ia;
    d_read = dr; d_write = dw; d_address = da; d_wdata = dwd;
    pmem_resp = pr; pmem_rdata = prd;
    #1;
    m_i_done = (m_owner == 1) && pr;
    m_d_done = (m_owner == 2) && pr;
    check_val("pmem_read",    LINE_W'(pmem_read),    LINE_W'((m_owner != 0) && !m_is_wr));
    check_val("pmem_write",   LINE_W'(pmem_write),   LINE_W'((m_owner != 0) &&  m_is_wr));
    check_val("pmem_address", LINE_W'(pmem_address), LINE_W'(m_addr));
    check_val("pmem_wdata",   pmem_wdata,            m_wdata);
    check_val("pmem_timeout", LINE_W'(pmem_timeout), LINE_W'(m_to));
    check_val("i_resp",       LINE_W'(i_resp),       LINE_W'(m_i_done));
    check_val("d_resp",       LINE_W'(d_resp),       LINE_W'(m_d_done));
    check_val("i_rdata",      i_rdata,               prd);
    check_val("d_rdata",      d_rdata,               prd);
    if (m_owner == 0) begin
      pick = 0;
      if (ir && (dr || dw)) pick = m_last_d ? 1 : 2;
      else if (dr || dw)    pick = 2;
      else if (ir)          pick = 1;
      if (pick == 1) begin
        m_addr = ia; m_is_wr = 1'b0; m_last_d = 1'b0; m_wait = 0;
      end else if (pick == 2) begin
        m_addr = da; m_wdata = dwd; m_is_wr = dw; m_last_d = 1'b1; m_wait = 0;
      end
      if (pick != 0) grant_log.push_back(pick);
      m_owner = pick;
    end else if (pr) begin
      m_owner = 0;
    end else begin
      m_wait++;
      if (m_wait >= TIMEOUT) m_to = 1'b1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("rst_pmem_read",    LINE_W'(pmem_read),    '0);
    check_val("rst_pmem_write",   LINE_W'(pmem_write),   '0);
    check_val("rst_pmem_address", LINE_W'(pmem_address), '0);
    check_val("rst_pmem_wdata",   pmem_wdata,            '0);
    check_val("rst_pmem_timeout", LINE_W'(pmem_timeout), '0);
    model_reset();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, rand_line());
  endtask

  logic [LINE_W-1:0] pat_a5;
  logic [LINE_W-1:0] pat_p;
  logic [ADDR_W-1:0] ra_i, ra_d;
  logic [LINE_W-1:0] rw_d;
  bit                i_pend, d_pend;
  int                d_kind;
  int                gi;

  initial begin
    pat_a5 = {16{8'hA5}};
    pat_p  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    model_reset();
    #12;
    apply_reset();
    idle_cycles(2);

    // lone icache read, response after three waiting cycles
    step(1'b1, 16'h1230, 1'b0, 1'b0, 16'h0, '0, 1'b0, '0);
    for (int k = 0; k < 3; k++) step(1'b1, 16'h1230, 1'b0, 1'b0, 16'h0, '0, 1'b0, rand_line());
    step(1'b1, 16'h1230, 1'b0, 1'b0, 16'h0, '0, 1'b1, pat_a5);
    check_val("lone_i_resp_seen", LINE_W'(m_i_done), LINE_W'(1));
    idle_cycles(2);

    // simultaneous requests out of reset: D first, then strict alternation
    apply_reset();
    grant_log.delete();
    i_pend = 1'b1; d_pend = 1'b1;
    for (int k = 0; k < 40 && grant_log.size() < 8; k++) begin
      step(i_pend, 16'h1000, d_pend, 1'b0, 16'h2000, '0, m_owner != 0 && pmem_read, rand_line());
      if (m_i_done) i_pend = 1'b0; else i_pend = 1'b1;
      if (m_d_done) d_pend = 1'b0; else d_pend = 1'b1;
    end
    check_val("alt_count", LINE_W'(grant_log.size()), LINE_W'(8));
    for (int k = 0; k < grant_log.size(); k++)
      check_val("alt_order", LINE_W'(grant_log[k]), LINE_W'((k % 2 == 0) ? 2 : 1));
    idle_cycles(3);

    // writeback with inputs changing after the grant
    apply_reset();
    step(1'b0, '0, 1'b0, 1'b1, 16'h4440, pat_p, 1'b0, '0);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0, 1'b1, 16'($urandom()), rand_line(), 1'b0, '0);
    check_val("wb_addr_held",  LINE_W'(pmem_address), LINE_W'(16'h4440));
    check_val("wb_wdata_held", pmem_wdata, pat_p);
    step(1'b0, '0, 1'b0, 1'b1, 16'h1111, rand_line(), 1'b1, '0);
    idle_cycles(2);

    // watchdog: withhold the response beyond TIMEOUT, then complete late
    apply_reset();
    step(1'b0, '0, 1'b1, 1'b0, 16'h0800, '0, 1'b0, '0);
    for (int k = 0; k < TIMEOUT + 3; k++) step(1'b0, '0, 1'b1, 1'b0, 16'h0800, '0, 1'b0, rand_line());
    step(1'b0, '0, 1'b1, 1'b0, 16'h0800, '0, 1'b1, rand_line());
    check_val("late_d_resp", LINE_W'(m_d_done), LINE_W'(1));
    idle_cycles(2);

    // requester drops while granted; stray response in IDLE
    apply_reset();
    step(1'b1, 16'h3330, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    step(1'b0, 16'h0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    step(1'b0, 16'h0, 1'b0, 1'b0, '0, '0, 1'b1, rand_line());
    check_val("drop_i_resp", LINE_W'(m_i_done), LINE_W'(1));
    step(1'b0, 16'h0, 1'b0, 1'b0, '0, '0, 1'b1, rand_line());
    step(1'b0, 16'h0, 1'b0, 1'b0, '0, '0, 1'b1, rand_line());

    // asynchronous reset in the middle of a grant
    step(1'b0, '0, 1'b1, 1'b1, 16'h5550, pat_p, 1'b0, '0);
    step(1'b0, '0, 1'b1, 1'b1, 16'h5550, pat_p, 1'b0, '0);
    apply_reset();

    // randomized traffic in several reset-separated blocks
    for (int blk = 0; blk < 4; blk++) begin
      apply_reset();
      i_pend = 1'b0; d_pend = 1'b0; d_kind = 0;
      ra_i = '0; ra_d = '0; rw_d = '0;
      for (int c = 0; c < 600; c++) begin
        if (!i_pend && $urandom_range(3) == 0) begin i_pend = 1'b1; ra_i = 16'($urandom()); end
        if (!d_pend && $urandom_range(3) == 0) begin
          d_pend = 1'b1; d_kind = $urandom_range(8) == 0 ? 2 : int'($urandom_range(1));
          ra_d = 16'($urandom()); rw_d = rand_line();
        end
        if (i_pend && $urandom_range(40) == 0) i_pend = 1'b0;
        if ($urandom_range(3) == 0) begin ra_i = 16'($urandom()); ra_d = 16'($urandom()); rw_d = rand_line(); end
        step(i_pend, ra_i, d_pend && d_kind != 1, d_pend && d_kind != 0, ra_d, rw_d,
             $urandom_range(2 + blk) == 0, rand_line());
        if (m_i_done) i_pend = 1'b0;
        if (m_d_done) d_pend = 1'b0;
      end
    end

    gi = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
